// File: rtl/dmem_lsu_pkg.sv
// Shared definitions for the dmem load/store unit.
// Funct3 codes, lane masks, FSM encoding and request bundle.
package dmem_lsu_pkg;

  localparam int XLEN = 32;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  localparam logic [1:0] SZ_B   = 2'b00;
  localparam logic [1:0] SZ_H   = 2'b01;
  localparam logic [1:0] SZ_W   = 2'b10;

  localparam logic [3:0] AMP_NONE = 4'b0000;
  localparam logic [3:0] AMP_B0   = 4'b0001;
  localparam logic [3:0] AMP_HLO  = 4'b0011;
  localparam logic [3:0] AMP_HHI  = 4'b1100;
  localparam logic [3:0] AMP_W    = 4'b1111;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_SETUP = 3'd2,
    S_WRITE = 3'd3,
    S_RESP  = 3'd4
  } state_t;

  // What the load path still needs after accept.
  typedef struct packed {
    logic [2:0] f3;
    logic [1:0] lane;
  } lsu_req_t;

  function automatic logic f3_legal(
    input logic       we,
    input logic [2:0] f3
  );
    logic ok;
    if (we)
      ok = (f3 == F3_SB) || (f3 == F3_SH) ||
           (f3 == F3_SW);
    else
      ok = (f3 == F3_LB) || (f3 == F3_LH) ||
           (f3 == F3_LW) || (f3 == F3_LBU) ||
           (f3 == F3_LHU);
    return ok;
  endfunction

  function automatic logic misaligned(
    input logic [1:0] sz,
    input logic [1:0] lane
  );
    logic m;
    m = 1'b0;
    unique case (1'b1)
      sz == SZ_H: m = lane[0];
      sz == SZ_W: m = |lane;
      default:    m = 1'b0;
    endcase
    return m;
  endfunction

  function automatic logic [3:0] lane_mask(
    input logic [1:0] sz,
    input logic [1:0] lane
  );
    logic [3:0] m;
    m = AMP_W;
    unique case (1'b1)
      sz == SZ_B: m = AMP_B0 << lane;
      sz == SZ_H: m = lane[1] ? AMP_HHI : AMP_HLO;
      default:    m = AMP_W;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/dmem_lsu_load_align.sv
// Load lane extraction: picks the addressed byte/half
// out of the read word and sign- or zero-extends it.
module lsu_load_align
  import dmem_lsu_pkg::*;
(
  input  logic [XLEN-1:0] word,
  input  logic [1:0]      off,
  input  logic [2:0]      funct3,
  output logic [XLEN-1:0] data
);

  logic [7:0]  b;
  logic [15:0] h;

  always_comb begin
    b    = word[{off, 3'b000} +: 8];
    h    = off[1] ? word[31:16] : word[15:0];
    data = word;
    unique case (funct3)
      F3_LB:   data = {{24{b[7]}}, b};
      F3_LBU:  data = {24'h0, b};
      F3_LH:   data = {{16{h[15]}}, h};
      F3_LHU:  data = {16'h0, h};
      default: data = word;
    endcase
  end

endmodule

// File: rtl/dmem_lsu.sv
// CPU-side load/store initiator for the byte-lane dmem.
// One request in flight; stores get a setup cycle before mem_we.
module dmem_lsu
  import dmem_lsu_pkg::*;
#(
  parameter int          ADDR_W    = 7,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic              mem_we,
  output logic [3:0]        mem_amp,
  output logic [ADDR_W-1:0] mem_ad,
  output logic [31:0]       mem_wd,
  input  logic [31:0]       mem_rd
);

  state_t          state;
  state_t          state_n;
  lsu_req_t        req_q;
  logic [3:0]      amp_q;
  logic [XLEN-1:0] off;
  logic [XLEN-1:0] ld_data;
  logic            acc;
  logic            bad;
  logic            oor;

  // Addresses below BASE_ADDR wrap high and fail the range test.
  assign off = req_addr - BASE_ADDR;
  assign oor = |off[XLEN-1:ADDR_W+2];
  assign acc = req_valid & req_ready;
  assign bad = !f3_legal(req_we, req_funct3) |
               misaligned(req_funct3[1:0], off[1:0]) |
               oor;

  lsu_load_align u_align (
    .word   (mem_rd),
    .off    (req_q.lane),
    .funct3 (req_q.f3),
    .data   (ld_data)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= S_IDLE;
      req_q      <= '0;
      amp_q      <= AMP_NONE;
      mem_ad     <= '0;
      mem_wd     <= '0;
      resp_err   <= 1'b0;
      resp_rdata <= '0;
    end else begin
      state <= state_n;
      if (acc) begin
        req_q.f3   <= req_funct3;
        req_q.lane <= off[1:0];
        amp_q      <= bad ? AMP_NONE
                          : lane_mask(req_funct3[1:0],
                                      off[1:0]);
        mem_ad     <= off[ADDR_W+1:2];
        mem_wd     <= req_wdata;
        resp_err   <= bad;
        resp_rdata <= '0;
      end else if (state == S_LOAD) begin
        resp_rdata <= ld_data;
      end
    end
  end

  always_comb begin
    state_n    = state;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    mem_we     = 1'b0;
    mem_amp    = AMP_NONE;
    unique case (state)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (bad)         state_n = S_RESP;
          else if (req_we) state_n = S_SETUP;
          else             state_n = S_LOAD;
        end
      end
      S_LOAD: begin
        mem_amp = amp_q;
        state_n = S_RESP;
      end
      S_SETUP: begin
        mem_amp = amp_q;
        state_n = S_WRITE;
      end
      S_WRITE: begin
        mem_amp = amp_q;
        mem_we  = 1'b1;
        state_n = S_RESP;
      end
      S_RESP: begin
        resp_valid = 1'b1;
        state_n    = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_dmem_lsu.sv
// Randomized scoreboard bench for dmem_lsu against a
// byte-array memory model.
module tb_dmem_lsu;

  localparam int AW      = 7;
  localparam int DEPTH_B = 4 << AW;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_we = 1'b0;
  logic [2:0]    req_funct3 = '0;
  logic [31:0]   req_addr = '0;
  logic [31:0]   req_wdata = '0;
  logic          resp_valid;
  logic [31:0]   resp_rdata;
  logic          resp_err;
  logic          mem_we;
  logic [3:0]    mem_amp;
  logic [AW-1:0] mem_ad;
  logic [31:0]   mem_wd;
  logic [31:0]   mem_rd;

  always #5 clk = ~clk;

  dmem_lsu #(.ADDR_W(AW), .BASE_ADDR(32'h0)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .mem_we     (mem_we),
    .mem_amp    (mem_amp),
    .mem_ad     (mem_ad),
    .mem_wd     (mem_wd),
    .mem_rd     (mem_rd)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // dmem: combinational read, lane write with replication.
  logic [31:0] dmem [1 << AW];
  logic [7:0]  refm [DEPTH_B];

  assign mem_rd = dmem[mem_ad];

  always @(posedge clk) begin
    if (mem_we) begin
      logic [31:0] rep;
      int pc;
      pc = $countones(mem_amp);
      if (pc == 1)      rep = {4{mem_wd[7:0]}};
      else if (pc == 2) rep = {2{mem_wd[15:0]}};
      else              rep = mem_wd;
      for (int i = 0; i < 4; i++)
        if (mem_amp[i])
          dmem[mem_ad][8*i +: 8] <= rep[8*i +: 8];
    end
  end

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          cyc;
  } resp_t;

  typedef struct {
    logic [AW-1:0] ad;
    logic [3:0]    amp;
    logic [31:0]   wd;
    int            cyc;
  } wr_t;

  resp_t rq[$];
  wr_t   wq[$];
  resp_t mr;
  wr_t   mw;

  logic          p_we;
  logic [3:0]    p_amp;
  logic [AW-1:0] p_ad;
  logic [31:0]   p_wd;

  always @(negedge clk) begin
    if (resp_valid) begin
      checks++;
      if (rq.size() == 0) begin
        errors++;
        $display("FAIL resp_unexpected cyc=%0d", cyc);
      end else begin
        mr = rq.pop_front();
        if (resp_rdata !== mr.rdata ||
            resp_err !== mr.err || cyc != mr.cyc) begin
          errors++;
          $display("FAIL resp got %h/%b@%0d want %h/%b@%0d",
                   resp_rdata, resp_err, cyc,
                   mr.rdata, mr.err, mr.cyc);
        end
      end
    end
    if (mem_we) begin
      checks++;
      if (wq.size() == 0) begin
        errors++;
        $display("FAIL write_unexpected cyc=%0d", cyc);
      end else begin
        mw = wq.pop_front();
        if (mem_ad !== mw.ad || mem_amp !== mw.amp ||
            mem_wd !== mw.wd || cyc != mw.cyc) begin
          errors++;
          $display("FAIL write got %h/%b/%h@%0d want %h/%b/%h@%0d",
                   mem_ad, mem_amp, mem_wd, cyc,
                   mw.ad, mw.amp, mw.wd, mw.cyc);
        end
      end
      checks++;
      if (p_we !== 1'b0 || p_amp !== mem_amp ||
          p_ad !== mem_ad || p_wd !== mem_wd) begin
        errors++;
        $display("FAIL setup got we=%b %h/%b/%h want 0 %h/%b/%h",
                 p_we, p_ad, p_amp, p_wd,
                 mem_ad, mem_amp, mem_wd);
      end
    end
    p_we  = mem_we;
    p_amp = mem_amp;
    p_ad  = mem_ad;
    p_wd  = mem_wd;
  end

  // Called at a negedge; returns at the negedge after accept.
  task automatic issue(
    input  logic        we,
    input  logic [2:0]  f3,
    input  logic [31:0] addr,
    input  logic [31:0] wd,
    output int          acc_cyc
  );
    int          n;
    int          nb;
    logic        legal;
    logic        err;
    logic [31:0] off;
    logic [31:0] v;
    logic [3:0]  eamp;
    resp_t       r;
    wr_t         w;
    n = 0;
    acc_cyc = -1;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout cyc=%0d got 0 want 1", cyc);
      return;
    end
    off   = addr;
    nb    = 1 << int'(f3[1:0]);
    legal = we ? (f3 <= 3'd2)
               : (f3 != 3'd3 && f3 != 3'd6 && f3 != 3'd7);
    err   = !legal || off >= DEPTH_B || (off % nb) != 0;
    eamp  = 4'(((1 << nb) - 1) << (off % 4));
    v     = 32'h0;
    if (!err && we) begin
      for (int i = 0; i < nb; i++)
        refm[off + i] = 8'(wd >> (8 * i));
    end else if (!err) begin
      for (int i = 0; i < nb; i++)
        v |= 32'(refm[off + i]) << (8 * i);
      if (!f3[2] && nb < 4 && v[8*nb-1])
        v |= 32'hFFFF_FFFF << (8 * nb);
    end
    acc_cyc = cyc + 1;
    r.rdata = v;
    r.err   = err;
    r.cyc   = err ? acc_cyc : (we ? acc_cyc + 2 : acc_cyc + 1);
    rq.push_back(r);
    if (!err && we) begin
      w.ad  = off[AW+1:2];
      w.amp = eamp;
      w.wd  = wd;
      w.cyc = acc_cyc + 1;
      wq.push_back(w);
    end
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wd;
    @(negedge clk);
    req_valid  = 1'b0;
    req_we     = 1'($urandom);
    req_funct3 = 3'($urandom);
    req_addr   = $urandom;
    req_wdata  = $urandom;
    checks++;
    if (err) begin
      if (mem_amp !== 4'b0 || mem_we !== 1'b0 ||
          req_ready !== 1'b0) begin
        errors++;
        $display("FAIL err_lanes got amp=%b we=%b rdy=%b want 0 0 0",
                 mem_amp, mem_we, req_ready);
      end
    end else begin
      if (mem_amp !== eamp || mem_ad !== off[AW+1:2] ||
          mem_we !== 1'b0 || req_ready !== 1'b0 ||
          (we && mem_wd !== wd)) begin
        errors++;
        $display("FAIL first_cycle got %h/%b/%h we=%b rdy=%b want %h/%b/%h 0 0",
                 mem_ad, mem_amp, mem_wd, mem_we, req_ready,
                 off[AW+1:2], eamp, wd);
      end
    end
  endtask

  int e1;
  int e2;
  int dummy;
  int bad_seen;

  initial begin
    for (int i = 0; i < (1 << AW); i++) begin
      dmem[i] = $urandom;
      for (int j = 0; j < 4; j++)
        refm[4*i + j] = dmem[i][8*j +: 8];
    end
    #1;
    checks++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0 ||
        resp_err !== 1'b0 || resp_rdata !== 32'h0 ||
        mem_we !== 1'b0 || mem_amp !== 4'h0 ||
        mem_ad !== '0 || mem_wd !== 32'h0) begin
      errors++;
      $display("FAIL reset_state rdy=%b rv=%b we=%b amp=%b ad=%h wd=%h",
               req_ready, resp_valid, mem_we, mem_amp,
               mem_ad, mem_wd);
    end
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);

    issue(1, 3'b010, 32'h10, 32'hDEAD_BEEF, dummy);
    issue(1, 3'b000, 32'h13, 32'h0000_00A5, dummy);
    issue(1, 3'b001, 32'h12, $urandom, dummy);
    issue(1, 3'b010, 32'h10, 32'hA512_3456, dummy);
    issue(0, 3'b000, 32'h13, 32'h0, dummy);
    issue(0, 3'b100, 32'h13, 32'h0, dummy);
    issue(1, 3'b010, 32'h10, 32'h8001_1234, dummy);
    issue(0, 3'b001, 32'h12, 32'h0, dummy);
    issue(0, 3'b101, 32'h12, 32'h0, dummy);
    issue(0, 3'b010, 32'h06, 32'h0, dummy);
    issue(1, 3'b001, 32'h11, 32'h1234, dummy);
    issue(0, 3'b010, 32'h200, 32'h0, dummy);
    issue(0, 3'b011, 32'h0, 32'h0, dummy);
    issue(1, 3'b011, 32'h0, 32'h0, dummy);
    issue(1, 3'b100, 32'h4, 32'h0, dummy);
    issue(0, 3'b010, 32'hFFFF_FFFC, 32'h0, dummy);

    issue(1, 3'b010, 32'h1FC, 32'hC0FF_EE11, e1);
    issue(0, 3'b010, 32'h1FC, 32'h0, e2);
    checks++;
    if (e2 != e1 + 4) begin
      errors++;
      $display("FAIL b2b_accept got %0d want %0d", e2, e1 + 4);
    end

    for (int i = 0; i < 300; i++) begin
      logic        we;
      logic [2:0]  f3;
      logic [31:0] a;
      int          sel;
      int          nb;
      we  = 1'($urandom);
      sel = $urandom_range(0, 9);
      if (sel == 0)  f3 = 3'($urandom);
      else if (we)   f3 = 3'($urandom_range(0, 2));
      else begin
        f3 = 3'($urandom_range(0, 4));
        if (f3 == 3'd3) f3 = 3'd5;
      end
      nb = 1 << int'(f3[1:0]);
      a  = 32'($urandom_range(0, (1 << AW) - 1)) * 4;
      if (sel == 1)
        a = 32'($urandom_range(0, 1023));
      else if (sel == 2)
        a = 32'(DEPTH_B) + 32'($urandom_range(0, 64)) * 4;
      else if (nb <= 4)
        a += 32'($urandom_range(0, 3)) & ~32'(nb - 1);
      issue(we, f3, a, $urandom, dummy);
    end

    // Reset while the store sits in its setup cycle.
    while (!req_ready) @(negedge clk);
    req_valid  = 1'b1;
    req_we     = 1'b1;
    req_funct3 = 3'b010;
    req_addr   = 32'h20;
    req_wdata  = 32'h5555_AAAA;
    @(negedge clk);
    req_valid = 1'b0;
    checks++;
    if (mem_we !== 1'b0 || mem_amp !== 4'hF) begin
      errors++;
      $display("FAIL setup_before_rst got we=%b amp=%b want 0 1111",
               mem_we, mem_amp);
    end
    #1 rstn = 1'b0;
    #1;
    checks++;
    if (mem_we !== 1'b0 || mem_amp !== 4'h0 ||
        mem_ad !== '0 || mem_wd !== 32'h0 ||
        resp_valid !== 1'b0 || resp_err !== 1'b0 ||
        resp_rdata !== 32'h0 || req_ready !== 1'b1) begin
      errors++;
      $display("FAIL mid_rst got we=%b amp=%b ad=%h wd=%h rv=%b rdy=%b",
               mem_we, mem_amp, mem_ad, mem_wd,
               resp_valid, req_ready);
    end
    @(negedge clk);
    rstn = 1'b1;
    bad_seen = 0;
    repeat (5) begin
      @(negedge clk);
      if (mem_we || resp_valid || !req_ready) bad_seen++;
    end
    checks++;
    if (bad_seen != 0) begin
      errors++;
      $display("FAIL after_rst got %0d bad cycles want 0", bad_seen);
    end
    checks++;
    if (dmem[8] !== {refm[35], refm[34], refm[33], refm[32]}) begin
      errors++;
      $display("FAIL rst_no_write got %h want %h", dmem[8],
               {refm[35], refm[34], refm[33], refm[32]});
    end

    repeat (10) @(negedge clk);
    checks++;
    if (rq.size() != 0 || wq.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d/%0d pending want 0/0",
               rq.size(), wq.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_lsu.md
Name: dmem_lsu

Overview:
CPU-side load/store initiator for the byte-lane data memory (dmem). It accepts one RV32I load/store request at a time from the pipeline MEM stage. It translates the request into the dmem port signals: word address, byte-lane mask `amp`, raw write data and write enable. For loads, it extracts and sign- or zero-extends the addressed byte or halfword from the 32-bit read word. It also sequences the memory's one-cycle write-data setup requirement and flags misaligned, out-of-range and illegal accesses.

Parameters:
- ADDR_W, 7, dmem word-address width (2^ADDR_W words).
- BASE_ADDR, 32'h0000_0000, byte address mapped to dmem word 0.

Ports:
- clk  in  1  system clock, all state updates on posedge.
- rstn  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted when req_valid & req_ready.
- req_we  in  1  1 = store, 0 = load.
- req_funct3  in  3  RV32I funct3: load 000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu; store 000 sb, 001 sh, 010 sw.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-justified.
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  32  extended load data; 0 for stores and errors.
- resp_err  out  1  access rejected, valid with resp_valid.
- mem_we  out  1  dmem write enable.
- mem_amp  out  4  byte-lane mask.
- mem_ad  out  ADDR_W  dmem word address.
- mem_wd  out  32  write data, unshifted; dmem replicates lanes itself.
- mem_rd  in  32  dmem combinational read word.

Behaviour:
- Reset values (asynchronous, while rstn=0): state IDLE; req_ready=1; resp_valid=0; resp_err=0; resp_rdata=0; mem_we=0; mem_amp=0; mem_ad=0; mem_wd=0.
- Output timing: all outputs are driven from registers or decoded from the state register only. mem_we is never combinational from request inputs.
- Acceptance: req_ready=1 only in IDLE. On accept, register we, funct3, offset = req_addr - BASE_ADDR, and wdata.
- Error check on accept. Error if any of:
  - illegal funct3 (load 011/110/111; store ≥ 011);
  - halfword access with offset[0]=1;
  - word access with offset[1:0]≠0;
  - offset[31:ADDR_W+2]≠0.
  On error: go to RESP with resp_err=1 and resp_rdata=0. No mem_we pulse occurs and mem_amp stays 0.
- Lane mask:
  - word: 1111;
  - half: 0011 if offset[1]=0, else 1100;
  - byte: one-hot 1<<offset[1:0].
- FSM states: IDLE, LOAD, SETUP, WRITE, RESP.
  - IDLE → LOAD on accepting a valid load.
  - IDLE → SETUP on accepting a valid store.
  - IDLE → RESP on accepting an erroneous request.
  - LOAD: mem_ad = offset[ADDR_W+1:2], mem_amp = mask. At the clock edge, capture mem_rd, extract the lane and extend. → RESP.
  - SETUP: mem_ad, mem_amp and mem_wd = wdata are stable; mem_we=0. dmem registers its lane data here. → WRITE.
  - WRITE: same ad/amp/wd held; mem_we=1 for exactly this one cycle. → RESP.
  - RESP: resp_valid=1 for one cycle; mem_amp=0, mem_we=0. → IDLE. A new request is acceptable the cycle after RESP.
- Latency, with accept at edge T:
  - load: resp_valid in cycle T+2;
  - store: mem_we in cycle T+2, resp_valid in T+3;
  - error: resp_valid in T+1.
- Load extraction:
  - byte: lane offset[1:0], sign-extend for lb, zero-extend for lbu.
  - half: lane offset[1], sign-extend for lh, zero-extend for lhu.
  - word: pass-through.
- Backpressure: no response backpressure; the consumer must sample resp_valid when it pulses.
- Mid-operation reset: rstn low during SETUP or WRITE deasserts mem_we immediately, and no further write occurs. The interrupted request is dropped with no response.
- Boundaries: the highest word (offset = 4·(2^ADDR_W)-4) is legal; offset = 4·2^ADDR_W raises an error. An address below BASE_ADDR wraps to a large offset and raises an error.

Decomposition:
- Shared defines: funct3 encodings for loads and stores, the AMP_* mask constants, and the FSM state encoding (3 bits, localparam set). XLEN comes from the existing defines file.
- One sub-module: `lsu_load_align` (combinational: word, offset[1:0], funct3 → 32-bit extended data). It is reused by the verification model.

Test Plan:
- sw, addr 0x10, wdata 0xDEADBEEF: mem_ad=4, mem_amp=1111, mem_wd=0xDEADBEEF stable in T+1 with mem_we=0. mem_we=1 only in T+2. resp_valid in T+3 with err=0 and rdata=0.
- sb, addr 0x13, wdata 0x000000A5: mem_amp=1000, mem_ad=4, mem_wd=0x000000A5. sh to 0x12 gives mem_amp=1100.
- lb, addr 0x13, with mem_rd=0xA5123456: resp_rdata=0xFFFFFFA5 at T+2. lbu gives 0x000000A5. lh at 0x12 with mem_rd=0x80011234 gives 0xFFFF8001; lhu gives 0x00008001.
- lw at 0x06, sh at 0x11, lw at 0x200 (ADDR_W=7), funct3=011 load: each gives resp_err=1 at T+1 with rdata=0. mem_we is never asserted and mem_amp stays 0.
- Back-to-back store then load at 0x1FC: the second request is accepted the cycle after the first RESP, req_ready=0 in between, and the load returns the stored word at max depth.
- rstn pulsed low in SETUP of a sw: mem_we never asserts, all outputs return to reset values, no resp_valid, and req_ready=1 after release.
